// File: rtl/cm_proto_pkg.sv
// cm_proto_pkg: CM bus guessing-protocol constants shared by the guesser and
// the responder, the responder FSM state type, and the leading-match helper.
package cm_proto_pkg;

  localparam logic [7:0] CM_START = 8'h01;
  localparam logic [7:0] CM_BEGIN = 8'h02;
  localparam logic [7:0] CM_YES   = 8'h03;
  localparam logic [7:0] CM_NO    = 8'h04;
  localparam logic [7:0] CM_END   = 8'h05;

  typedef enum logic [2:0] {
    ST_ANNOUNCE,
    ST_GAP,
    ST_CLOCKING,
    ST_DELAY,
    ST_REPLY,
    ST_RELEASE,
    ST_DONE
  } resp_state_e;

  // Number of consecutive equal bits between a and b, scanning from the MSB.
  function automatic logic [3:0] lead_match(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] m;
    logic       run;
    m   = 4'd0;
    run = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (run && (a[i] == b[i])) m = m + 4'd1;
      else                       run = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/cm_bus_if.sv
// cm_bus_if: tri-state adapter for the shared 8-bit CM bus.
//   data_out  in   byte to drive
//   drive_en  in   1 = drive data_out onto cm, 0 = release (Z)
//   data_in   out  current bus value
//   cm        io   the shared bus
module cm_bus_if (
  input  logic [7:0] data_out,
  input  logic       drive_en,
  output logic [7:0] data_in,
  inout  wire  [7:0] cm
);

  assign cm      = drive_en ? data_out : 8'hzz;
  assign data_in = cm;

endmodule

// File: rtl/inter_clk_gen.sv
// inter_clk_gen: registered interconnect clock, HALF_PERIOD cycles high then
// HALF_PERIOD cycles low while enabled; forced low and re-phased when disabled.
//   i_clk          in   system clock
//   i_rst          in   synchronous active-high reset
//   i_enable       in   run the clock; first rise follows the first enabled cycle
//   o_clk_inter    out  interconnect clock, idles low
//   o_rise_strobe  out  high in the first cycle o_clk_inter is high
//   o_fall_strobe  out  high in the first cycle o_clk_inter is low again
//   o_pulse_idx    out  index of the current pulse (advances on each fall)
module inter_clk_gen #(
  parameter int HALF_PERIOD = 25
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic       o_clk_inter,
  output logic       o_rise_strobe,
  output logic       o_fall_strobe,
  output logic [1:0] o_pulse_idx
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] HP_M1 = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          r_rise;
  logic          r_fall;
  logic [1:0]    r_idx;

  always_ff @(posedge i_clk) begin
    r_rise <= 1'b0;
    r_fall <= 1'b0;
    if (i_rst || !i_enable) begin
      r_clk <= 1'b0;
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == '0) begin
      r_clk <= ~r_clk;
      r_cnt <= HP_M1;
      if (r_clk) begin
        r_fall <= 1'b1;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_rise <= 1'b1;
      end
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_clk_inter   = r_clk;
  assign o_rise_strobe = r_rise;
  assign o_fall_strobe = r_fall;
  assign o_pulse_idx   = r_idx;

endmodule

// File: rtl/guess_responder.sv
// guess_responder: responder end of the CM bus guessing protocol. Announces
// BEGIN_GUESSING, clocks in START/guess/END frames with CLK_INTER, and replies
// YES/NO after BASE_DELAY + BIT_DELAY*m cycles (m = leading bits matching
// SECRET), an intentional timing side channel.
//   CLK_50     in   system clock
//   SW[0]      in   synchronous active-high reset
//   CM         io   shared bus, Z unless announcing or replying
//   CLK_INTER  out  interconnect clock
//   LED        out  last sampled guess byte
//   FOUND      out  sticky, set when YES is sent
//   FRAME_ERR  out  one-cycle pulse on a malformed frame
//   ATTEMPTS   out  frames received, saturating
module guess_responder
  import cm_proto_pkg::*;
#(
  parameter logic [7:0] SECRET        = 8'h5A,
  parameter int         HALF_PERIOD   = 25,
  parameter int         BASE_DELAY    = 8,
  parameter int         BIT_DELAY     = 16,
  parameter int         REPLY_HOLD    = 4,
  parameter int         ANNOUNCE_HOLD = 4
) (
  input  logic        CLK_50,
  input  logic [0:0]  SW,
  inout  wire  [7:0]  CM,
  output logic        CLK_INTER,
  output logic [7:0]  LED,
  output logic        FOUND,
  output logic        FRAME_ERR,
  output logic [15:0] ATTEMPTS
);

  localparam int MAX_D    = BASE_DELAY + BIT_DELAY * 8;
  localparam int DW       = ($clog2(MAX_D + 1) > 8) ? $clog2(MAX_D + 1) : 8;
  localparam int HOLD_MAX = (ANNOUNCE_HOLD > REPLY_HOLD) ? ANNOUNCE_HOLD : REPLY_HOLD;
  localparam int HW       = $clog2(HOLD_MAX + 2);

  resp_state_e r_state;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_fall_cnt;
  logic [DW-1:0] r_dly;
  logic [7:0]    r_s0, r_s1, r_s2;
  logic [7:0]    r_reply;
  logic          r_drive_en;
  logic [7:0]    r_data_out;

  logic          w_rst;
  logic [7:0]    w_cm_in;
  logic          w_rise, w_fall;
  logic [1:0]    w_idx;
  logic          w_frame_ok;
  logic [3:0]    w_m;
  logic [3:0]    w_m_eff;
  logic [DW-1:0] w_dly_load;

  assign w_rst      = SW[0];
  assign w_frame_ok = (r_s0 == CM_START) && (r_s2 == CM_END);
  assign w_m        = lead_match(r_s1, SECRET);
  assign w_m_eff    = w_frame_ok ? w_m : 4'd0;
  // DELAY is entered one cycle after the final fall and REPLY costs one more
  // transition, so the counter is loaded with D-2 to land the reply on D.
  assign w_dly_load = DW'(BASE_DELAY - 2) + DW'(BIT_DELAY) * DW'(w_m_eff);

  cm_bus_if u_bus (
    .data_out (r_data_out),
    .drive_en (r_drive_en),
    .data_in  (w_cm_in),
    .cm       (CM)
  );

  inter_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk (
    .i_clk         (CLK_50),
    .i_rst         (w_rst),
    .i_enable      (r_state == ST_CLOCKING),
    .o_clk_inter   (CLK_INTER),
    .o_rise_strobe (w_rise),
    .o_fall_strobe (w_fall),
    .o_pulse_idx   (w_idx)
  );

  always_ff @(posedge CLK_50) begin
    if (w_rst) begin
      r_state    <= ST_ANNOUNCE;
      r_hold     <= '0;
      r_fall_cnt <= 2'd0;
      r_dly      <= '0;
      r_s0       <= 8'h00;
      r_s1       <= 8'h00;
      r_s2       <= 8'h00;
      r_reply    <= CM_NO;
      r_drive_en <= 1'b0;
      r_data_out <= 8'h00;
      LED        <= 8'h00;
      FOUND      <= 1'b0;
      FRAME_ERR  <= 1'b0;
      ATTEMPTS   <= 16'h0000;
    end else begin
      FRAME_ERR <= 1'b0;
      case (r_state)
        ST_ANNOUNCE: begin
          if (r_hold == HW'(ANNOUNCE_HOLD)) begin
            r_drive_en <= 1'b0;
            r_hold     <= '0;
            r_state    <= ST_GAP;
          end else begin
            r_drive_en <= 1'b1;
            r_data_out <= CM_BEGIN;
            r_hold     <= r_hold + HW'(1);
          end
        end
        ST_GAP, ST_RELEASE: begin
          if (r_hold == HW'(1)) begin
            r_hold     <= '0;
            r_fall_cnt <= 2'd0;
            r_state    <= ST_CLOCKING;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        ST_CLOCKING: begin
          // Guesser changes CM on falls, so each rise sees a settled byte.
          if (w_rise) begin
            case (w_idx)
              2'd1:    r_s0 <= w_cm_in;
              2'd2:    r_s1 <= w_cm_in;
              2'd3:    r_s2 <= w_cm_in;
              default: ;
            endcase
          end
          if (w_fall) begin
            if (r_fall_cnt == 2'd3) begin
              r_fall_cnt <= 2'd0;
              r_dly      <= w_dly_load;
              r_reply    <= (w_frame_ok && (w_m == 4'd8)) ? CM_YES : CM_NO;
              LED        <= r_s1;
              FRAME_ERR  <= ~w_frame_ok;
              if (ATTEMPTS != 16'hFFFF) ATTEMPTS <= ATTEMPTS + 16'd1;
              r_state    <= ST_DELAY;
            end else begin
              r_fall_cnt <= r_fall_cnt + 2'd1;
            end
          end
        end
        ST_DELAY: begin
          if (r_dly == '0) begin
            r_drive_en <= 1'b1;
            r_data_out <= r_reply;
            r_hold     <= '0;
            if (r_reply == CM_YES) FOUND <= 1'b1;
            r_state    <= ST_REPLY;
          end else begin
            r_dly <= r_dly - DW'(1);
          end
        end
        ST_REPLY: begin
          if (r_hold == HW'(REPLY_HOLD - 1)) begin
            r_drive_en <= 1'b0;
            r_hold     <= '0;
            r_state    <= (r_data_out == CM_YES) ? ST_DONE : ST_RELEASE;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        ST_DONE: ;
        default: r_state <= ST_ANNOUNCE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_responder.sv
module tb_guess_responder;
  import cm_proto_pkg::*;

  localparam logic [7:0] SECRET = 8'h5A;
  localparam int BASE = 8;
  localparam int BIT  = 16;
  localparam int RH   = 4;

  typedef struct {
    logic [7:0] b;
    int         lat;
    int         len;
  } rep_t;

  logic        clk = 1'b0;
  logic [0:0]  sw = 1'b1;
  wire  [7:0]  cm;
  logic        clk_inter;
  logic [7:0]  led;
  logic        found;
  logic        frame_err;
  logic [15:0] attempts;

  // guesser model state
  logic       g_en = 1'b0;
  logic [7:0] g_val = 8'h00;
  logic [7:0] g_guess = 8'h00;
  logic [7:0] g_end = 8'h05;
  int         g_falls = 0;
  logic       prev_ci = 1'b0;

  // monitor state
  int   cyc = 0;
  int   fall_cyc = 0;
  int   final_falls = 0;
  int   conflicts = 0;
  int   fe_cnt = 0;
  logic in_rep = 1'b0;
  int   rep_start = 0;
  int   rep_len = 0;
  logic [7:0] rep_byte = 8'h00;

  rep_t exp_q[$];
  rep_t obs_q[$];

  int checks = 0;
  int failures = 0;

  assign cm = (g_en && !sw[0]) ? g_val : 8'hzz;

  always #5 clk = ~clk;

  guess_responder dut (
    .CLK_50    (clk),
    .SW        (sw),
    .CM        (cm),
    .CLK_INTER (clk_inter),
    .LED       (led),
    .FOUND     (found),
    .FRAME_ERR (frame_err),
    .ATTEMPTS  (attempts)
  );

  function automatic bit released(input logic [7:0] v);
    return $isunknown(v) || (v == 8'h00);
  endfunction

  function automatic rep_t model(input logic [7:0] g, input logic [7:0] e);
    rep_t r;
    logic [7:0] x;
    int m;
    x = g ^ SECRET;
    m = 0;
    while (m < 8 && x[7-m] == 1'b0) m++;
    if (e != CM_END) m = 0;
    r.b   = (m == 8) ? CM_YES : CM_NO;
    r.lat = BASE + BIT * m;
    r.len = RH;
    return r;
  endfunction

  // Guesser model (advances on CLK_INTER falls) plus reply monitor.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_ci <= clk_inter;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (g_en && !sw[0] && cm !== g_val) conflicts <= conflicts + 1;
    if (sw[0]) begin
      g_en    <= 1'b0;
      g_falls <= 0;
      in_rep  <= 1'b0;
    end else begin
      if (prev_ci && !clk_inter) begin
        case (g_falls)
          0: begin g_en <= 1'b1; g_val <= CM_START; end
          1: g_val <= g_guess;
          2: g_val <= g_end;
          default: g_en <= 1'b0;
        endcase
        g_falls <= (g_falls + 1) % 4;
        if (g_falls == 3) begin
          fall_cyc    <= cyc;
          final_falls <= final_falls + 1;
        end
      end
      if (!g_en && (cm == CM_YES || cm == CM_NO)) begin
        if (!in_rep) begin
          in_rep    <= 1'b1;
          rep_start <= cyc;
          rep_byte  <= cm;
          rep_len   <= 1;
        end else begin
          rep_len <= rep_len + 1;
        end
      end else if (in_rep) begin
        in_rep <= 1'b0;
        obs_q.push_back('{b: rep_byte, lat: rep_start - fall_cyc, len: rep_len});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 sw = 1'b1;
    repeat (3) @(posedge clk);
    #1 sw = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] guess, input logic [7:0] endb);
    g_guess = guess;
    g_end   = endb;
    do_reset();
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(model(guess, endb));
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_q.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    @(posedge clk); #1 sw = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (clk_inter !== 1'b0) begin failures++; $display("FAIL rst_clk_inter: got %b want 0", clk_inter); end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL rst_led: got %h want 00", led); end
    checks++; if (found !== 1'b0) begin failures++; $display("FAIL rst_found: got %b want 0", found); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (attempts !== 16'h0000) begin failures++; $display("FAIL rst_attempts: got %h want 0000", attempts); end
    checks++; if (!released(cm)) begin failures++; $display("FAIL rst_bus: got %h want released", cm); end
    @(posedge clk); #1 sw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cm !== CM_BEGIN) begin failures++; $display("FAIL announce_first: got %h want 02", cm); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (cm === CM_BEGIN) n++; else break;
      @(negedge clk);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL announce_len: got %0d want 4", n); end
  endtask

  task automatic test_no_m1();
    rep_t o, e;
    bit ok;
    int fe0;
    start_frame(8'h06, CM_END);
    fe0 = fe_cnt;
    wait_obs(1000, ok);
    o = ok ? obs_q.pop_front() : '{b: 8'h00, lat: -1, len: 0};
    e = exp_q.pop_front();
    checks++; if (!ok || o.b !== e.b || o.lat != e.lat || o.len != e.len) begin
      failures++; $display("FAIL m1_reply: got byte=%h lat=%0d len=%0d want byte=%h lat=%0d len=%0d", o.b, o.lat, o.len, e.b, e.lat, e.len); end
    checks++; if (led !== 8'h06) begin failures++; $display("FAIL m1_led: got %h want 06", led); end
    checks++; if (attempts !== 16'd1) begin failures++; $display("FAIL m1_attempts: got %0d want 1", attempts); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL m1_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_mismatch();
    logic [7:0] guesses [2];
    rep_t o, e;
    bit ok;
    guesses[0] = 8'hDA;
    guesses[1] = 8'h5B;
    for (int k = 0; k < 2; k++) begin
      start_frame(guesses[k], CM_END);
      wait_obs(1000, ok);
      o = ok ? obs_q.pop_front() : '{b: 8'h00, lat: -1, len: 0};
      e = exp_q.pop_front();
      checks++; if (!ok || o.b !== e.b || o.lat != e.lat || o.len != e.len) begin
        failures++; $display("FAIL mismatch_reply_%h: got byte=%h lat=%0d len=%0d want byte=%h lat=%0d len=%0d", guesses[k], o.b, o.lat, o.len, e.b, e.lat, e.len); end
      checks++; if (led !== guesses[k]) begin failures++; $display("FAIL mismatch_led: got %h want %h", led, guesses[k]); end
    end
  endtask

  task automatic test_frame_err();
    rep_t o, e;
    bit ok;
    int fe0;
    start_frame(8'h06, 8'h07);
    fe0 = fe_cnt;
    wait_obs(1000, ok);
    o = ok ? obs_q.pop_front() : '{b: 8'h00, lat: -1, len: 0};
    e = exp_q.pop_front();
    checks++; if (!ok || o.b !== e.b || o.lat != e.lat || o.len != e.len) begin
      failures++; $display("FAIL ferr_reply: got byte=%h lat=%0d len=%0d want byte=%h lat=%0d len=%0d", o.b, o.lat, o.len, e.b, e.lat, e.len); end
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    checks++; if (attempts !== 16'd1) begin failures++; $display("FAIL ferr_attempts: got %0d want 1", attempts); end
    checks++; if (led !== 8'h06) begin failures++; $display("FAIL ferr_led: got %h want 06", led); end
  endtask

  task automatic test_yes();
    rep_t o, e;
    bit ok;
    int viol;
    start_frame(SECRET, CM_END);
    wait_obs(1000, ok);
    o = ok ? obs_q.pop_front() : '{b: 8'h00, lat: -1, len: 0};
    e = exp_q.pop_front();
    checks++; if (!ok || o.b !== e.b || o.lat != e.lat || o.len != e.len) begin
      failures++; $display("FAIL yes_reply: got byte=%h lat=%0d len=%0d want byte=%h lat=%0d len=%0d", o.b, o.lat, o.len, e.b, e.lat, e.len); end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL yes_found: got %b want 1", found); end
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (clk_inter !== 1'b0 || !released(cm)) viol++;
    end
    checks++; if (viol != 0 || obs_q.size() != 0) begin failures++; $display("FAIL done_idle: got %0d active cycles, %0d replies want 0", viol, obs_q.size()); end
    checks++; if (found !== 1'b1 || attempts !== 16'd1) begin failures++; $display("FAIL done_state: got found=%b attempts=%0d want 1/1", found, attempts); end
  endtask

  task automatic test_reset_mid();
    int ff0, n;
    start_frame(8'h5B, CM_END);
    ff0 = final_falls;
    n = 0;
    while (final_falls == ff0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin failures++; $display("FAIL mid_delay_wait: got timeout want final fall"); end
    repeat (50) @(negedge clk);
    @(posedge clk); #1 sw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (clk_inter !== 1'b0 || !released(cm) || attempts !== 16'd0) begin
      failures++; $display("FAIL mid_delay_reset: got ci=%b cm=%h att=%0d want 0/released/0", clk_inter, cm, attempts); end
    @(posedge clk); #1 sw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cm !== CM_BEGIN) begin failures++; $display("FAIL mid_delay_announce: got %h want 02", cm); end
    // second pulse high: guesser is driving START, responder is mid-CLOCKING
    n = 0;
    while (!(g_falls == 1 && clk_inter === 1'b1) && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin failures++; $display("FAIL mid_clk_wait: got timeout want pulse 2"); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 sw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (clk_inter !== 1'b0 || !released(cm)) begin
      failures++; $display("FAIL mid_clk_reset: got ci=%b cm=%h want 0/released", clk_inter, cm); end
    @(posedge clk); #1 sw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cm !== CM_BEGIN) begin failures++; $display("FAIL mid_clk_announce: got %h want 02", cm); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_sweep();
    rep_t o, e;
    bit ok, done;
    int frames, conf0;
    g_guess = 8'h06;
    g_end   = CM_END;
    do_reset();
    obs_q.delete();
    exp_q.delete();
    conf0  = conflicts;
    frames = 0;
    done   = 1'b0;
    while (!done && frames < 100) begin
      exp_q.push_back(model(g_guess, g_end));
      wait_obs(1000, ok);
      frames++;
      o = ok ? obs_q.pop_front() : '{b: 8'h00, lat: -1, len: 0};
      e = exp_q.pop_front();
      checks++;
      if (!ok || o.b !== e.b || o.lat != e.lat || o.len != e.len) begin
        failures++; done = 1'b1;
        $display("FAIL sweep_reply_%h: got byte=%h lat=%0d len=%0d want byte=%h lat=%0d len=%0d", g_guess, o.b, o.lat, o.len, e.b, e.lat, e.len);
      end else if (o.b == CM_YES) begin
        done = 1'b1;
      end else begin
        g_guess = g_guess + 8'd1;
      end
    end
    checks++; if (frames != 85) begin failures++; $display("FAIL sweep_frames: got %0d want 85", frames); end
    checks++; if (attempts !== 16'd85) begin failures++; $display("FAIL sweep_attempts: got %0d want 85", attempts); end
    checks++; if (led !== 8'h5A || found !== 1'b1) begin failures++; $display("FAIL sweep_final: got led=%h found=%b want 5a/1", led, found); end
    checks++; if (conflicts - conf0 != 0) begin failures++; $display("FAIL sweep_contention: got %0d cycles want 0", conflicts - conf0); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_no_m1();
    test_mismatch();
    test_frame_err();
    test_yes();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/guess_responder.md
# guess_responder

Responder end of the CM bus guessing protocol, the counterpart of the FPGA guesser. It sits on the same 8-bit bidirectional CM bus and drives the interconnect clock. It announces BEGIN_GUESSING, clocks in START/guess/END frames, and compares each guess against a secret byte. It replies YES or NO after a data-dependent delay that grows with the number of leading matching bits, giving a deliberate timing side channel for attack experiments.

## Interface
- SECRET, 8'h5A: byte the guess is compared against.
- HALF_PERIOD, 25: CLK_50 cycles per CLK_INTER half-period. Must be at least 4.
- BASE_DELAY, 8: reply-delay floor in cycles. Must be at least 2, which provides the bus turnaround.
- BIT_DELAY, 16: extra cycles per leading matching bit.
- REPLY_HOLD, 4: cycles the reply byte is driven.
- ANNOUNCE_HOLD, 4: cycles BEGIN_GUESSING is driven.
- CLK_50  input  1  system clock. Single clock domain; everything is sampled on its rising edge.
- SW  input  [0:0]  SW[0] is the reset: synchronous, active-high.
- CM  inout  8  shared bus. Released (Z) except when this block is driving it.
- CLK_INTER  output  1  interconnect clock. Registered, glitch-free, idles low.
- LED  output  8  last sampled guess byte.
- FOUND  output  1  sticky; set when YES is sent.
- FRAME_ERR  output  1  one-cycle pulse when a frame fails its check.
- ATTEMPTS  output  16  number of frames received; saturates at 16'hFFFF.

## Operation
- Protocol bytes: START 0x01, BEGIN_GUESSING 0x02, YES 0x03, NO 0x04, END 0x05.
- ANNOUNCE: drive 0x02 for ANNOUNCE_HOLD cycles, then go to GAP.
- GAP: bus released for 2 cycles, then go to CLOCKING.
- CLOCKING: emit exactly 4 CLK_INTER pulses.
  - Each pulse is high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
  - The guesser advances its output on each falling edge.
  - Sample CM on the rising edge of pulses 2, 3 and 4, capturing s0, s1 and s2.
  - After the pulse-4 fall, go to DELAY.
- Frame check:
  - s0 must be 0x01 and s2 must be 0x05.
  - On failure: pulse FRAME_ERR, force the reply to NO with m=0, and still increment ATTEMPTS.
  - LED takes s1 on every frame.
- Match count m: the number of consecutive equal bits between s1 and SECRET, counted MSB-first.
  - Range 0..8.
  - m = 8 means the guess is correct.
- DELAY: wait D = BASE_DELAY + BIT_DELAY*m cycles, measured from the CLK_50 cycle in which CLK_INTER goes low at the end of pulse 4.
  - The delay counter is at least 8 bits wide, sized from the parameters.
- REPLY: drive YES if m == 8, otherwise NO, for REPLY_HOLD cycles. Then release the bus.
- After NO: 2 released cycles, then CLOCKING again. There is no re-announce, because the guesser is waiting for a clock fall.
- After YES: go to DONE. Set FOUND, keep CLK_INTER low, keep the bus released, and stay there until reset.
- Reset at any point:
  - CLK_INTER goes to 0 and the bus is released in the same cycle.
  - LED = 0, FOUND = 0, FRAME_ERR = 0, ATTEMPTS = 0.
  - The FSM returns to ANNOUNCE on the first cycle after SW[0] deasserts.
- FSM states: ANNOUNCE, GAP, CLOCKING, DELAY, REPLY, RELEASE, DONE.

## Timing
- The bus is never driven during CLOCKING, DELAY, GAP, RELEASE or DONE.
- Drive windows:
  - 0x02 during ANNOUNCE.
  - The reply byte during REPLY.
- Sampling margin: the guesser's bus output trails a CLK_INTER fall by up to 3 cycles. Sampling at the next rise, HALF_PERIOD cycles later, is therefore safe for HALF_PERIOD ≥ 4.
- Frame length is 8*HALF_PERIOD cycles (200 at the default).
- The reply appears on CM exactly D cycles after the final fall, with ±0 cycle jitter. The delay must be exact, because it is the measured side channel.
- ATTEMPTS increments in the cycle DELAY is entered.
- FRAME_ERR pulses in that same cycle.

## Structure
- Protocol byte constants go in the shared protocol header/package cm_proto_pkg, also used by the guesser.
- The tri-state is the existing cm_bus_if. Hook it up as data_out/drive_en/data_in/cm. No local tri-state logic.
- Sub-module inter_clk_gen:
  - Inputs: enable, HALF_PERIOD.
  - Outputs: registered CLK_INTER, a one-cycle rise_strobe, a one-cycle fall_strobe, and a 2-bit pulse index.
  - The FSM counts falls to end CLOCKING.

## Test plan
- Defaults, guesser model sends guess 0x06 (m=1) -> NO appears 24 cycles after the pulse-4 fall; LED=0x06; ATTEMPTS=1.
- Guess 0x5A -> YES after 136 cycles; FOUND=1; CLK_INTER stays low and the bus stays Z for the following 1000 cycles.
- Guess 0xDA (MSB differs, m=0) -> NO after 8 cycles. Guess 0x5B (m=7) -> NO after 120 cycles.
- Corrupt END to 0x07 -> FRAME_ERR pulses once; NO after 8 cycles; ATTEMPTS increments.
- Full sweep with the real guesser from 0x06 upward -> YES on the 85th frame (0x5A); no cycle with both sides driving CM.
- Assert SW[0] mid-DELAY and mid-CLOCKING -> bus released and CLK_INTER=0 that cycle; after release, 0x02 reappears on the next cycle.
